bcd_binary: RTL and testbench
=============================

# bcd_binary

Sequential BCD-to-binary converter, the inverse of the existing combinational binary-to-BCD block. It accepts a packed multi-digit BCD word over a valid/ready handshake. It converts the word one digit per cycle by Horner accumulation (acc = acc·10 + digit) and presents the binary result, plus an invalid-digit flag, on a second valid/ready handshake. It sits between keypad/display-side BCD sources and binary arithmetic datapaths.

## Interface
- DIGITS, 2, number of BCD digits in the input word (≥1).
- BIN_W, 7, binary output width. Must satisfy 2^BIN_W > 10^DIGITS − 1 (7 for 2 digits, 10 for 3).
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  in_bcd is valid.
- in_ready  output  1  block can accept a word. Equals (state==IDLE) && rst_n.
- in_bcd  input  4·DIGITS  packed BCD; bits [4·DIGITS−1 -: 4] are the most significant digit.
- out_valid  output  1  out_bin/out_err are valid.
- out_ready  input  1  consumer accepts the result.
- out_bin  output  BIN_W  binary value.
- out_err  output  1  at least one input digit was > 9.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid: capture in_bcd into the digit shift register, set acc=0, err=0, cnt=DIGITS−1, go to CONV.
  - CONV: each cycle, acc ← (acc<<3)+(acc<<1)+top_digit, truncated to BIN_W bits. Also err ← err | (top_digit > 9), and the shift register shifts left by 4. When cnt==0 go to DONE; otherwise cnt−−.
  - DONE: out_valid=1. out_bin=acc, out_err=err, both held stable until out_ready. On out_ready go to IDLE.
- Arithmetic: intermediate sum computed at BIN_W+4 bits, result truncated to BIN_W.
- Invalid digits (10–15) are still used arithmetically. out_bin = (Σ dᵢ·10ⁱ) mod 2^BIN_W, with out_err=1.
- in_valid is ignored outside IDLE. in_bcd is sampled only at the accept edge and may change afterwards.
- out_bin is a don't-care while out_valid=0. The bench checks it only when out_valid=1.
- Reset (rst_n=0 at a rising edge, in any state) aborts any conversion and returns to IDLE. The pending result is discarded.
- Reset values: state=IDLE, out_valid=0, out_bin=0, out_err=0, cnt=0. in_ready=0 while rst_n=0, and 1 on the first cycle after reset is released.

## Timing
- Accept edge E0: in_valid && in_ready.
- CONV occupies the DIGITS cycles after E0. out_valid rises immediately after edge E0+DIGITS. Latency is DIGITS cycles.
- Result handshake completes at the edge where out_valid && out_ready. in_ready is 1 in the following cycle.
- With out_ready tied high and in_valid tied high, accepts are spaced DIGITS+2 cycles apart.
- out_valid never deasserts without an out_ready handshake or a reset. out_bin/out_err do not change while out_valid=1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Shared package bcd_pkg holds:
  - state enum {IDLE, CONV, DONE}
  - BCD_DIGIT_W=4
  - BCD_MAX=4'd9
  - function mul10_add(acc, digit)
- One natural sub-module: bcd_mac10. It is combinational acc·10+digit with the digit>9 flag, parameterised by BIN_W, and instantiated once. Everything else stays in bcd_binary.
- Width assertion on BIN_W versus DIGITS in an elaboration-time check.

## Test plan
- DIGITS=2, BIN_W=7, in_bcd=8'h00, out_ready=1 → out_valid exactly 2 cycles after accept, out_bin=0, out_err=0.
- in_bcd=8'h99 → out_bin=7'd99, out_err=0. Then in_bcd=8'h07 → out_bin=7, confirming acc clears between words.
- in_bcd=8'h42, out_ready held 0 for 5 cycles while in_valid=1 with 8'h11 → out_valid and out_bin=42 stay stable and in_ready=0. After out_ready, the next accept yields 11.
- in_bcd=8'h1A → out_err=1, out_bin=20 (1·10+10).
- Accept 8'h57, then drive rst_n=0 on the next edge → out_valid=0, out_bin=0, out_err=0, no result emitted. After release, in_ready=1 and 8'h13 → 13.
- Back-to-back with in_valid=out_ready=1: 8'h01, 8'h10, 8'h98 → 1, 10, 98, spaced 4 cycles apart. DIGITS=3, BIN_W=10 with 12'h999 → 999 after 3 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
// Holds the FSM state encoding, BCD digit constants and the x10+digit step.
// Pure declarations; no logic of its own.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Working width of mul10_add; callers truncate the result to their own width.
  localparam int MAC_W = 32;

  // One Horner step: acc*10 + digit, built from shifts so it maps to two adders.
  function automatic logic [MAC_W-1:0] mul10_add(input logic [MAC_W-1:0] acc,
                                                 input logic [BCD_DIGIT_W-1:0] digit);
    return (acc << 3) + (acc << 1) + {{(MAC_W-BCD_DIGIT_W){1'b0}}, digit};
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit step with invalid-digit detection.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the enclosing FSM decides when the result is captured.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BIN_W = 7
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       result,
  output logic                   bad_digit
);

  // The sum needs BIN_W+4 bits before truncation, which must fit the helper width.
  if (BIN_W + BCD_DIGIT_W > MAC_W) begin : g_width_chk
    $error("bcd_mac10: BIN_W too large for mul10_add working width");
  end

  // Keeping only the low BIN_W bits gives the product-sum modulo 2^BIN_W.
  assign result    = BIN_W'(mul10_add(MAC_W'(acc), digit));
  assign bad_digit = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_binary.sv
// Sequential BCD-to-binary converter, one digit per cycle by Horner accumulation.
// Latency: DIGITS cycles from accept edge to out_valid; DIGITS+2 cycle throughput.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module bcd_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              out_bin,
  output logic                          out_err
);

  localparam int WORD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // The largest DIGITS-digit decimal value must be representable in BIN_W bits.
  if (DIGITS < 1) begin : g_digits_chk
    $error("bcd_binary: DIGITS must be at least 1");
  end
  if ((64'd1 << BIN_W) <= (pow10(DIGITS) - 64'd1)) begin : g_width_chk
    $error("bcd_binary: BIN_W too narrow for DIGITS");
  end

  state_t                  state;
  state_t                  state_nxt;
  logic [WORD_W-1:0]       sreg;
  logic [BIN_W-1:0]        acc;
  logic [BIN_W-1:0]        acc_nxt;
  logic                    err;
  logic [CNT_W-1:0]        cnt;
  logic [BCD_DIGIT_W-1:0]  top_digit;
  logic                    digit_bad;

  assign top_digit = sreg[WORD_W-1 -: BCD_DIGIT_W];

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc       (acc),
    .digit     (top_digit),
    .result    (acc_nxt),
    .bad_digit (digit_bad)
  );

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, count digits in CONV, wait for consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = CONV;
      CONV:    if (cnt == '0)    state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Datapath: capture word on accept, then fold in one digit (MSD first) per CONV cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
      acc  <= '0;
      err  <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg <= in_bcd;
            acc  <= '0;
            err  <= 1'b0;
            cnt  <= CNT_W'(DIGITS - 1);
          end
        end
        CONV: begin
          acc  <= acc_nxt;
          err  <= err | digit_bad;
          sreg <= sreg << BCD_DIGIT_W;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // in_ready depends only on state and reset, never on in_valid.
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign out_bin   = acc;
  assign out_err   = err;

endmodule

// File: tb/tb_bcd_binary.sv
// Self-checking bench for bcd_binary: 2-digit and 3-digit instances, scoreboard queue.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Every wait on the DUT is bounded; expiry counts as a failure.
module tb_bcd_binary;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready;
  logic [7:0]  in_bcd;
  logic        in_ready, out_valid, out_err;
  logic [6:0]  out_bin;

  logic        in_valid3, out_ready3;
  logic [11:0] in_bcd3;
  logic        in_ready3, out_valid3, out_err3;
  logic [9:0]  out_bin3;

  bcd_binary #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_err(out_err)
  );

  bcd_binary #(.DIGITS(3), .BIN_W(10)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_bcd(in_bcd3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_bin(out_bin3), .out_err(out_err3)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] exp_q[$];
  logic       exp_err_q[$];

  // Reference: sum of d_i * 10^i, reduced modulo 2^binw.
  function automatic logic [9:0] model_bin(input logic [11:0] w, input int digits, input int binw);
    longint v = 0;
    longint p = 1;
    for (int i = 0; i < digits; i++) begin
      v += longint'(w[4*i +: 4]) * p;
      p *= 10;
    end
    return 10'(v % (longint'(1) << binw));
  endfunction

  function automatic logic model_err(input logic [11:0] w, input int digits);
    logic e = 1'b0;
    for (int i = 0; i < digits; i++) if (w[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  // Offers a 2-digit word; returns the accept edge index or -1 on timeout.
  task automatic send2(input logic [7:0] w, output int acc_edge);
    acc_edge = -1;
    in_bcd   = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_edge = cyc + 1;
        exp_q.push_back(model_bin({4'h0, w}, 2, 7));
        exp_err_q.push_back(model_err({4'h0, w}, 2));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid of the 2-digit DUT; returns the edge count when seen, -1 on timeout.
  task automatic wait_out2(output int seen);
    seen = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_bcd = 8'h00;
    in_valid3 = 1'b0; out_ready3 = 1'b1; in_bcd3 = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_bin !== 7'd0) begin fails++; $display("FAIL reset_out_bin got %0d want 0", out_bin); end
    checks++; if (out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err got %b want 0", out_err); end
    checks++; if (out_bin3 !== 10'd0) begin fails++; $display("FAIL reset_out_bin3 got %0d want 0", out_bin3); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    checks++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL release_in_ready3 got %b want 1", in_ready3); end
  endtask

  task automatic test_zero_latency;
    int e0, seen;
    logic [9:0] eb; logic ee;
    send2(8'h00, e0);
    checks++; if (e0 < 0) begin fails++; $display("FAIL zero_accept got timeout want accept"); end
    wait_out2(seen);
    checks++; if (seen < 0 || seen - e0 != 2) begin fails++; $display("FAIL zero_latency got %0d want 2", seen - e0); end
    eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
    checks++; if ({3'b0, out_bin} !== eb) begin fails++; $display("FAIL zero_bin got %0d want %0d", out_bin, eb); end
    checks++; if (out_err !== ee) begin fails++; $display("FAIL zero_err got %b want %b", out_err, ee); end
    @(posedge clk); #1;
  endtask

  task automatic test_max_and_clear;
    int e0, seen;
    logic [9:0] eb; logic ee;
    logic [7:0] words [2] = '{8'h99, 8'h07};
    for (int k = 0; k < 2; k++) begin
      send2(words[k], e0);
      wait_out2(seen);
      checks++; if (seen < 0) begin fails++; $display("FAIL max_clear_timeout word %h got none want out_valid", words[k]); end
      eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++; if ({3'b0, out_bin} !== eb) begin fails++; $display("FAIL max_clear_bin word %h got %0d want %0d", words[k], out_bin, eb); end
      checks++; if (out_err !== ee) begin fails++; $display("FAIL max_clear_err word %h got %b want %b", words[k], out_err, ee); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int e0, seen;
    logic [9:0] eb; logic ee;
    out_ready = 1'b0;
    send2(8'h42, e0);
    // Offer the next word immediately; it must not disturb the held conversion.
    in_bcd = 8'h11; in_valid = 1'b1;
    wait_out2(seen);
    checks++; if (seen < 0) begin fails++; $display("FAIL bp_timeout got none want out_valid"); end
    eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", i, out_valid); end
      checks++; if ({3'b0, out_bin} !== eb) begin fails++; $display("FAIL bp_hold_bin cycle %0d got %0d want %0d", i, out_bin, eb); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    checks++; if (out_err !== ee) begin fails++; $display("FAIL bp_err got %b want %b", out_err, ee); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    send2(8'h11, e0);
    wait_out2(seen);
    eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
    checks++; if (seen < 0 || {3'b0, out_bin} !== eb) begin fails++; $display("FAIL bp_next_bin got %0d want %0d", out_bin, eb); end
    @(posedge clk); #1;
  endtask

  task automatic test_invalid_digit;
    int e0, seen;
    logic [9:0] eb; logic ee;
    send2(8'h1A, e0);
    wait_out2(seen);
    eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
    checks++; if (seen < 0 || {3'b0, out_bin} !== eb) begin fails++; $display("FAIL invalid_bin got %0d want %0d", out_bin, eb); end
    checks++; if (out_err !== ee) begin fails++; $display("FAIL invalid_err got %b want %b", out_err, ee); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int e0, seen;
    logic [9:0] eb; logic ee;
    send2(8'h57, e0);
    void'(exp_q.pop_back()); void'(exp_err_q.pop_back());
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %b want 0", out_valid); end
    checks++; if (out_bin !== 7'd0) begin fails++; $display("FAIL abort_bin got %0d want 0", out_bin); end
    checks++; if (out_err !== 1'b0) begin fails++; $display("FAIL abort_err got %b want 0", out_err); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_release_ready got %b want 1", in_ready); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_no_result got %b want 0", out_valid); end
    end
    send2(8'h13, e0);
    wait_out2(seen);
    eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
    checks++; if (seen < 0 || {3'b0, out_bin} !== eb) begin fails++; $display("FAIL abort_next_bin got %0d want %0d", out_bin, eb); end
    checks++; if (out_err !== ee) begin fails++; $display("FAIL abort_next_err got %b want %b", out_err, ee); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3] = '{8'h01, 8'h10, 8'h98};
    int acc_e [3];
    int out_e [3];
    out_ready = 1'b1;
    in_valid  = 1'b1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          acc_e[k] = -1;
          in_bcd = words[k];
          for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
              acc_e[k] = cyc + 1;
              exp_q.push_back(model_bin({4'h0, words[k]}, 2, 7));
              exp_err_q.push_back(model_err({4'h0, words[k]}, 2));
              break;
            end
          end
          @(posedge clk); #1;
        end
      end
      begin
        logic [9:0] eb; logic ee;
        for (int k = 0; k < 3; k++) begin
          wait_out2(out_e[k]);
          checks++;
          if (out_e[k] < 0 || exp_q.size() == 0) begin
            fails++; $display("FAIL b2b_timeout result %0d got none want out_valid", k);
          end else begin
            eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
            if ({3'b0, out_bin} !== eb || out_err !== ee) begin
              fails++; $display("FAIL b2b_result %0d got %0d/%b want %0d/%b", k, out_bin, out_err, eb, ee);
            end
          end
          @(posedge clk); #1;
        end
      end
    join
    in_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      checks++; if (acc_e[k] - acc_e[k-1] != 4) begin fails++; $display("FAIL b2b_accept_spacing %0d got %0d want 4", k, acc_e[k] - acc_e[k-1]); end
      checks++; if (out_e[k] - out_e[k-1] != 4) begin fails++; $display("FAIL b2b_output_spacing %0d got %0d want 4", k, out_e[k] - out_e[k-1]); end
    end
  endtask

  task automatic test_three_digits;
    logic [11:0] words [2] = '{12'h999, 12'h5A0};
    int e0, seen;
    logic [9:0] eb; logic ee;
    out_ready3 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e0 = -1; seen = -1;
      in_bcd3 = words[k]; in_valid3 = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (in_ready3) begin
          e0 = cyc + 1;
          exp_q.push_back(model_bin(words[k], 3, 10));
          exp_err_q.push_back(model_err(words[k], 3));
          break;
        end
      end
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (out_valid3) begin seen = cyc; break; end
      end
      checks++; if (e0 < 0 || seen < 0 || seen - e0 != 3) begin fails++; $display("FAIL d3_latency word %h got %0d want 3", words[k], seen - e0); end
      if (exp_q.size() != 0) begin
        eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
        checks++; if (out_bin3 !== eb) begin fails++; $display("FAIL d3_bin word %h got %0d want %0d", words[k], out_bin3, eb); end
        checks++; if (out_err3 !== ee) begin fails++; $display("FAIL d3_err word %h got %b want %b", words[k], out_err3, ee); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_latency();
    test_max_and_clear();
    test_backpressure();
    test_invalid_digit();
    test_reset_abort();
    test_back_to_back();
    test_three_digits();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
